// File: rtl/mux_rr.sv
// 4-to-1 round-robin merging multiplexer with a registered output link and source tag.
// Define MUX_LOCK_EN to hold the grant on one channel until its in_last beat (packet lock).
module mux_rr #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            in_valid,
  output logic [3:0]            in_ready,
  input  logic [4*DATA_W-1:0]   in_data,
  input  logic [3:0]            in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_sel,
  output logic                  out_last
);

  logic [1:0] ptr_r;
  logic [1:0] ptr_nxt_s;
  logic [3:0] elig_s;
  logic [1:0] grant_s;
  logic [1:0] idx_s;
  logic       grant_vld_s;
  logic       load_s;
  logic       fire_s;
  logic       last_beat_s;

`ifdef MUX_LOCK_EN
  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} lock_state_t;
  lock_state_t state_r, state_nxt_s;
  logic [1:0]  lock_ch_r, lock_ch_nxt_s;

  // Eligibility narrows to the locked channel while a packet is in flight
  always_comb begin
    elig_s      = in_valid;
    last_beat_s = in_last[grant_s];
    if (state_r == LOCK) begin
      elig_s = in_valid & (4'b0001 << lock_ch_r);
    end else begin
      elig_s = in_valid;
    end
  end
`else
  logic unused_last_s;
  assign unused_last_s = ^in_last;

  // Every beat arbitrates independently; end-of-packet is not tracked
  always_comb begin
    elig_s      = in_valid;
    last_beat_s = 1'b0;
  end
`endif

  assign load_s = en & (~out_valid | out_ready);

  // Scan ptr, ptr+1, ... and keep the nearest eligible channel
  always_comb begin
    grant_s     = 2'd0;
    grant_vld_s = 1'b0;
    idx_s       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx_s = ptr_r + 2'(k);
      if (elig_s[idx_s]) begin
        grant_s     = idx_s;
        grant_vld_s = 1'b1;
      end else begin
        grant_s     = grant_s;
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign fire_s   = load_s & grant_vld_s & ~rst;
  assign in_ready = fire_s ? (4'b0001 << grant_s) : 4'b0000;

`ifdef MUX_LOCK_EN
  // Lock FSM next state; ptr only moves on IDLE grants and on packet end
  always_comb begin
    state_nxt_s   = state_r;
    lock_ch_nxt_s = lock_ch_r;
    ptr_nxt_s     = ptr_r;
    case (state_r)
      IDLE: begin
        if (fire_s) begin
          ptr_nxt_s = grant_s + 2'd1;
          if (!in_last[grant_s]) begin
            state_nxt_s   = LOCK;
            lock_ch_nxt_s = grant_s;
          end else begin
            state_nxt_s   = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCK: begin
        if (fire_s && in_last[grant_s]) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = lock_ch_r + 2'd1;
        end else begin
          state_nxt_s = LOCK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Lock FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      lock_ch_r <= 2'd0;
    end else begin
      state_r   <= state_nxt_s;
      lock_ch_r <= lock_ch_nxt_s;
    end
  end
`else
  // Pointer advances past each granted channel
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (fire_s) begin
      ptr_nxt_s = grant_s + 2'd1;
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end
`endif

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 2'd0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Output beat register: load on grant, clear valid when drained without replacement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      out_last  <= 1'b0;
    end else if (fire_s) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_s*DATA_W +: DATA_W];
      out_sel   <= grant_s;
      out_last  <= last_beat_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
